mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single owner of the byte-wide external RAM/IO port.
- Arbitrates between the instruction-fetch requester (I-cache miss path) and the MEM-stage data requester.
- Sequences multi-byte accesses one byte per cycle and assembles little-endian results.
- Returns completion as single-cycle ok pulses; sits between the core pipeline and the RAM/UART bus.

Parameters:
- ADDR_W, 32, address width of all address ports
- IO_SEL, 2'b11, value of addr[17:16] that marks the memory-mapped IO region

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  branch redirect; aborts an in-flight instruction fetch
- inst_fe  in  1  fetch request, level-held until inst_ok
- inst_fpc  in  ADDR_W  fetch address, word aligned
- inst_ok  out  1  one-cycle pulse; inst_o/inst_pc valid
- inst_o  out  32  fetched word
- inst_pc  out  ADDR_W  address the fetched word belongs to
- mem_req  in  1  data request, level-held until mem_ok
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data byte address
- mem_width  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- mem_wdata  in  32  write data, little-endian
- mem_ok  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, zero-extended; valid with mem_ok
- ram_din  in  8  RAM read byte; valid 1 cycle after ram_a
- ram_dout  out  8  RAM write byte
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  1 = write strobe for this cycle
- io_buffer_full  in  1  UART transmit buffer full

Behaviour:
- States: IDLE, IFETCH, DREAD, DWRITE.
- 3-bit byte counter cnt; N = 1/2/4 from width (fetch is always N = 4). Byte k addresses base + k.
- ram_a, ram_dout and ram_wr are registered.
- Reset: state IDLE, cnt 0. All outputs 0: inst_ok, mem_ok, ram_wr, ram_a, ram_dout, inst_o, inst_pc, mem_rdata.
- Arbitration happens only in IDLE:
  - mem_req beats inst_fe.
  - An accepted access is never preempted by the other requester.
  - The request, address, width and wdata are latched on acceptance.
- Read timing: request accepted at edge E0. Byte k is presented on ram_a in cycle E0+1+k and captured from ram_din one cycle later.
  - The ok pulse is in cycle E0+N+2: inst_ok at E0+6; mem_ok at E0+3 for byte, E0+4 for half, E0+6 for word.
- Write timing: byte k is driven with ram_wr = 1 in cycle E0+1+k; mem_ok is in cycle E0+N+1.
- IO write stall: if the latched address has addr[17:16] == IO_SEL and io_buffer_full = 1, the pending byte is not issued.
  - ram_wr is held 0 and cnt is frozen until io_buffer_full = 0. Ok latency grows by the stall cycles.
- IO reads: issued exactly once per byte, never speculatively; flush never cancels an IO access.
- flush:
  - In IFETCH: next state IDLE, no inst_ok, partial word discarded. Any RAM read already issued completes harmlessly.
  - flush in the same cycle the inst_ok pulse would occur suppresses that pulse.
  - flush never affects DREAD/DWRITE.
- Ok cycle: the state returns to IDLE. Requests are not sampled that cycle; the requester drops its request after ok, and re-arbitration starts the next cycle. Minimum gap is one idle cycle.
- inst_o/inst_pc and mem_rdata hold their values after ok until the next completion.
- ram_wr is 0 in every cycle not issuing a write byte. ram_a holds its last value when idle.
- mem_width = 3: treated as word (no error reporting).
- Reset mid-access: abandons the access immediately; no ok pulse, no further RAM writes.

Decomposition:
- The shared `define header (alongside InstAddrBus/InstBus) gains:
  - state encodings MemIdle/MemIFetch/MemDRead/MemDWrite
  - width codes MemByte/MemHalf/MemWord
  - IO_SEL
- No sub-module; a single FSM plus byte-lane shift/assembly logic is natural.

Test Plan:
- Reset, then inst_fe = 1 with inst_fpc = 0x100; RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 on consecutive cycles; inst_ok at E0+6 with inst_o = 0x00100513, inst_pc = 0x100.
- mem_req and inst_fe raised in the same cycle; write word 0xDEADBEEF to 0x200 -> bytes EF, BE, AD, DE at 0x200..0x203 with ram_wr = 1; mem_ok at E0+5; fetch starts after the idle cycle.
- Half read at 0x301 with RAM bytes 0xFF, 0x80 -> mem_rdata = 0x000080FF; mem_ok at E0+4.
- Byte write 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 during the stall; one write of 0x41 follows; mem_ok at E0+5.
- Fetch at 0x40, flush asserted at E0+3 -> no inst_ok; IDLE next cycle; a new fetch at 0x80 completes with inst_pc = 0x80.
- rst asserted during the 3rd byte of a word write -> no further ram_wr pulses, no mem_ok; all outputs 0 the next cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide RAM/IO port controller:
// FSM states, access width codes and the IO region selector.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MemIdle   = 2'd0,
        MemIFetch = 2'd1,
        MemDRead  = 2'd2,
        MemDWrite = 2'd3
    } mem_state_t;

    localparam logic [1:0] MemByte  = 2'd0;
    localparam logic [1:0] MemHalf  = 2'd1;
    localparam logic [1:0] MemWord  = 2'd2;
    localparam logic [1:0] MemIoSel = 2'b11;

    // Width code 3 is folded into a word access.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        logic [2:0] n;
        case (w)
            MemByte: n = 3'd1;
            MemHalf: n = 3'd2;
            MemWord: n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial owner of the external RAM/IO port: arbitrates fetch vs.
// data requests and assembles/splits little-endian multi-byte accesses.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = MemIoSel
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_fe,
    input  logic [ADDR_W-1:0] inst_fpc,
    output logic              inst_ok,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_width,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ok,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full
);

    mem_state_t        state;
    logic [2:0]        cnt;
    logic [2:0]        rcnt;
    logic [2:0]        nb;
    logic              p1;
    logic              p2;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rd_next;
    logic              is_io;
    logic              stall;
    logic              issue;
    logic              last_cap;
    logic              fetch_kill;

    assign is_io      = (base[17:16] == IO_SEL);
    assign stall      = is_io & io_buffer_full;
    assign issue      = (cnt < nb);
    assign last_cap   = p2 && (rcnt == nb - 3'd1);
    assign fetch_kill = (state == MemIFetch) && flush && !is_io;

    always_comb begin
        rd_next = rbuf;
        rd_next[{rcnt[1:0], 3'b000} +: 8] = ram_din;
    end

    // p1/p2 track a read byte through the one-cycle RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MemIdle;
            cnt       <= '0;
            rcnt      <= '0;
            nb        <= 3'd4;
            p1        <= 1'b0;
            p2        <= 1'b0;
            base      <= '0;
            wdata     <= '0;
            rbuf      <= '0;
            inst_ok   <= 1'b0;
            mem_ok    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_a     <= '0;
            ram_dout  <= '0;
            inst_o    <= '0;
            inst_pc   <= '0;
            mem_rdata <= '0;
        end else begin
            inst_ok <= 1'b0;
            mem_ok  <= 1'b0;
            ram_wr  <= 1'b0;
            unique case (state)
                MemIdle: begin
                    cnt  <= '0;
                    rcnt <= '0;
                    p1   <= 1'b0;
                    p2   <= 1'b0;
                    rbuf <= '0;
                    if (!inst_ok && !mem_ok) begin
                        if (mem_req) begin
                            state <= mem_we ? MemDWrite : MemDRead;
                            base  <= mem_addr;
                            nb    <= width_bytes(mem_width);
                            wdata <= mem_wdata;
                        end else if (inst_fe) begin
                            state <= MemIFetch;
                            base  <= inst_fpc;
                            nb    <= 3'd4;
                        end
                    end
                end
                MemIFetch, MemDRead: begin
                    if (fetch_kill) begin
                        state <= MemIdle;
                    end else begin
                        p1 <= issue;
                        p2 <= p1;
                        if (issue) begin
                            ram_a <= base + ADDR_W'(cnt);
                            cnt   <= cnt + 3'd1;
                        end
                        if (p2) begin
                            rbuf <= rd_next;
                            rcnt <= rcnt + 3'd1;
                        end
                        if (last_cap) begin
                            state <= MemIdle;
                            if (state == MemIFetch) begin
                                inst_ok <= 1'b1;
                                inst_o  <= rd_next;
                                inst_pc <= base;
                            end else begin
                                mem_ok    <= 1'b1;
                                mem_rdata <= rd_next;
                            end
                        end
                    end
                end
                MemDWrite: begin
                    if (cnt == nb) begin
                        state  <= MemIdle;
                        mem_ok <= 1'b1;
                    end else if (!stall) begin
                        ram_wr   <= 1'b1;
                        ram_a    <= base + ADDR_W'(cnt);
                        ram_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
                        cnt      <= cnt + 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected port events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inst_fe = 1'b0;
    logic [31:0] inst_fpc = '0;
    logic        inst_ok;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [1:0]  mem_width = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ok;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = '0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full = 1'b0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_fe(inst_fe), .inst_fpc(inst_fpc),
        .inst_ok(inst_ok), .inst_o(inst_o), .inst_pc(inst_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_width(mem_width), .mem_wdata(mem_wdata),
        .mem_ok(mem_ok), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
        .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } evt_t;

    evt_t q_rd[$];
    evt_t q_wr[$];
    evt_t q_inst[$];
    evt_t q_mem[$];

    int          vecs = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          rst_q = 1'b1;
    logic [31:0] prev_a = '0;
    logic [7:0]  ram [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
        ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
        ram[10'h104] = 8'h93;
        ram[10'h301] = 8'hFF; ram[10'h302] = 8'h80;
        ram[10'h040] = 8'h11; ram[10'h041] = 8'h22;
        ram[10'h042] = 8'h33; ram[10'h043] = 8'h44;
        ram[10'h080] = 8'h6F;
    end

    always @(posedge clk) begin
        ram_din <= ram[ram_a[9:0]];
        cyc     <= cyc + 1;
        rst_q   <= rst;
    end

    function automatic evt_t ev(input int c, input logic [31:0] a,
                                input logic [31:0] d);
        evt_t e;
        e.cyc = c;
        e.a   = a;
        e.d   = d;
        return e;
    endfunction

    task automatic take(input string nm, input bit have, input evt_t e,
                        input logic [31:0] a, input logic [31:0] d);
        vecs++;
        if (!have) begin
            fails++;
            $display("FAIL %s: unexpected at cycle %0d a=%h d=%h",
                     nm, cyc, a, d);
        end else if (e.cyc != cyc || e.a !== a || e.d !== d) begin
            fails++;
            $display("FAIL %s: got cycle %0d a=%h d=%h, want cycle %0d a=%h d=%h",
                     nm, cyc, a, d, e.cyc, e.a, e.d);
        end
    endtask

    always @(negedge clk) begin : monitor
        evt_t e;
        bit   have;
        if (!rst_q) begin
            if (ram_wr) begin
                e = ev(0, 0, 0);
                have = q_wr.size() > 0;
                if (have) e = q_wr.pop_front();
                take("ram_wr", have, e, ram_a, {24'h0, ram_dout});
            end else if (ram_a !== prev_a) begin
                e = ev(0, 0, 0);
                have = q_rd.size() > 0;
                if (have) e = q_rd.pop_front();
                take("ram_rd", have, e, ram_a, 32'h0);
            end
            if (inst_ok) begin
                e = ev(0, 0, 0);
                have = q_inst.size() > 0;
                if (have) e = q_inst.pop_front();
                take("inst_ok", have, e, inst_pc, inst_o);
            end
            if (mem_ok) begin
                e = ev(0, 0, 0);
                have = q_mem.size() > 0;
                if (have) e = q_mem.pop_front();
                take("mem_ok", have, e, 32'h0, mem_rdata);
            end
        end
        prev_a = ram_a;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_inst_ok"}, {31'h0, inst_ok}, 32'h0);
        chk({tag, "_mem_ok"}, {31'h0, mem_ok}, 32'h0);
        chk({tag, "_ram_wr"}, {31'h0, ram_wr}, 32'h0);
        chk({tag, "_ram_a"}, ram_a, 32'h0);
        chk({tag, "_ram_dout"}, {24'h0, ram_dout}, 32'h0);
        chk({tag, "_inst_o"}, inst_o, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
    endtask

    task automatic wait_ok(input bit inst, input int lim, input string nm);
        int n = 0;
        while (!(inst ? inst_ok : mem_ok) && n < lim) begin
            tick(1);
            n++;
        end
        if (n >= lim) begin
            vecs++;
            fails++;
            $display("FAIL %s: no ok pulse within %0d cycles", nm, lim);
        end
    endtask

    task automatic push_reads(input int e0, input logic [31:0] a, input int n);
        for (int k = 0; k < n; k++) q_rd.push_back(ev(e0 + 1 + k, a + k, 32'h0));
    endtask

    initial begin
        int e0;
        int e1;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(2);

        // Word fetch at 0x100.
        e0 = cyc + 1;
        inst_fe = 1'b1;
        inst_fpc = 32'h100;
        push_reads(e0, 32'h100, 4);
        q_inst.push_back(ev(e0 + 6, 32'h100, 32'h00100513));
        wait_ok(1'b1, 20, "fetch_100");
        inst_fe = 1'b0;
        tick(1);

        // Simultaneous requests: data write wins, fetch follows after a gap.
        e0 = cyc + 1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200;
        mem_width = 2'd2; mem_wdata = 32'hDEADBEEF;
        inst_fe = 1'b1; inst_fpc = 32'h104;
        q_wr.push_back(ev(e0 + 1, 32'h200, 32'hEF));
        q_wr.push_back(ev(e0 + 2, 32'h201, 32'hBE));
        q_wr.push_back(ev(e0 + 3, 32'h202, 32'hAD));
        q_wr.push_back(ev(e0 + 4, 32'h203, 32'hDE));
        q_mem.push_back(ev(e0 + 5, 32'h0, 32'h0));
        push_reads(e0 + 7, 32'h104, 4);
        q_inst.push_back(ev(e0 + 13, 32'h104, 32'h00000093));
        wait_ok(1'b0, 20, "write_200");
        mem_req = 1'b0;
        wait_ok(1'b1, 20, "fetch_104");
        inst_fe = 1'b0;
        tick(1);

        // Half read at 0x301.
        e0 = cyc + 1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h301; mem_width = 2'd1;
        push_reads(e0, 32'h301, 2);
        q_mem.push_back(ev(e0 + 4, 32'h0, 32'h000080FF));
        wait_ok(1'b0, 20, "half_301");
        mem_req = 1'b0;
        tick(1);
        chk("inst_o_hold", inst_o, 32'h00000093);
        chk("inst_pc_hold", inst_pc, 32'h104);

        // IO byte write stalled three cycles by a full transmit buffer.
        e0 = cyc + 1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h30000;
        mem_width = 2'd0; mem_wdata = 32'hAABBCC41;
        q_wr.push_back(ev(e0 + 4, 32'h30000, 32'h41));
        q_mem.push_back(ev(e0 + 5, 32'h0, 32'h000080FF));
        tick(1);
        io_buffer_full = 1'b1;
        tick(3);
        io_buffer_full = 1'b0;
        wait_ok(1'b0, 20, "io_write");
        mem_req = 1'b0;
        tick(1);

        // Fetch at 0x40 flushed mid-way, redirected to 0x80.
        e0 = cyc + 1;
        inst_fe = 1'b1; inst_fpc = 32'h40;
        push_reads(e0, 32'h40, 3);
        tick(4);
        flush = 1'b1;
        inst_fpc = 32'h80;
        tick(1);
        flush = 1'b0;
        e1 = cyc + 1;
        push_reads(e1, 32'h80, 4);
        q_inst.push_back(ev(e1 + 6, 32'h80, 32'h0000006F));
        wait_ok(1'b1, 20, "fetch_80");
        inst_fe = 1'b0;
        tick(1);

        // Width code 3 behaves as a word read.
        e0 = cyc + 1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_width = 2'd3;
        push_reads(e0, 32'h100, 4);
        q_mem.push_back(ev(e0 + 6, 32'h0, 32'h00100513));
        wait_ok(1'b0, 20, "width3_read");
        mem_req = 1'b0;
        tick(1);

        // Reset during the third byte of a word write.
        e0 = cyc + 1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h240;
        mem_width = 2'd2; mem_wdata = 32'hCAFEF00D;
        q_wr.push_back(ev(e0 + 1, 32'h240, 32'h0D));
        q_wr.push_back(ev(e0 + 2, 32'h241, 32'hF0));
        q_wr.push_back(ev(e0 + 3, 32'h242, 32'hFE));
        tick(4);
        rst = 1'b1;
        tick(1);
        check_zero("midreset");
        rst = 1'b0;
        mem_req = 1'b0;
        tick(10);

        chk("left_rd", q_rd.size(), 32'h0);
        chk("left_wr", q_wr.size(), 32'h0);
        chk("left_inst", q_inst.size(), 32'h0);
        chk("left_mem", q_mem.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
